// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline types: the control word carried between stages and its encodings.
package cpu_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // An invalid slot must not change architectural state, so its side-effect bits are dropped.
  function automatic ctrl_t ctrl_qualify(input ctrl_t c, input logic valid);
    ctrl_t q_s;
    q_s = c;
    if (!valid) begin
      q_s.reg_write = 1'b0;
      q_s.mem_write = 1'b0;
      q_s.jump      = 1'b0;
      q_s.branch    = 1'b0;
    end else begin
      q_s = c;
    end
    return q_s;
  endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline flop: synchronous active-low reset, clear beats enable.
module pipe_reg_en_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // State update with reset > clear > enable priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/id_ex_register.sv
// Decode->Execute pipeline register with stall/flush and a saturating bubble counter.
module id_ex_register
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic [2:0]        ALUControlD,
  input  logic              ALUSrcD,
  output logic              ValidE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic              ALUSrcE,
  output logic [CNT_W-1:0]  BubbleCntE
);

  localparam int DATA_W = 5 * XLEN + 3 * REG_AW;

  ctrl_t             ctrl_raw_s;
  ctrl_t             ctrl_d_s;
  ctrl_t             ctrl_q_s;
  logic [DATA_W-1:0] data_d_s;
  logic [DATA_W-1:0] data_q_s;
  logic              load_en_s;
  logic              bubble_s;
  logic [CNT_W-1:0]  bubble_cnt_r;

  assign ctrl_raw_s = '{reg_write:   RegWriteD,
                        result_src:  ResultSrcD,
                        mem_write:   MemWriteD,
                        jump:        JumpD,
                        branch:      BranchD,
                        alu_control: ALUControlD,
                        alu_src:     ALUSrcD};

  // Gate side-effect control bits of an invalid decode slot before they are captured.
  always_comb begin
    ctrl_d_s = ctrl_qualify(ctrl_raw_s, ValidD);
  end

  assign data_d_s  = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
  assign load_en_s = ~StallE;
  // Flush wins over stall, so the bubble term is evaluated before the stall gate.
  assign bubble_s  = FlushE | (~StallE & ~ValidD);

  pipe_reg_en_clr #(.W($bits(ctrl_t))) u_ctrl (
    .clk(clk), .rst_n(rst_n), .en(load_en_s), .clr(FlushE), .d(ctrl_d_s), .q(ctrl_q_s)
  );

  pipe_reg_en_clr #(.W(DATA_W)) u_data (
    .clk(clk), .rst_n(rst_n), .en(load_en_s), .clr(FlushE), .d(data_d_s), .q(data_q_s)
  );

  pipe_reg_en_clr #(.W(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .en(load_en_s), .clr(FlushE), .d(ValidD), .q(ValidE)
  );

  // Saturating bubble counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_r <= '0;
    end else if (bubble_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE} = data_q_s;

  assign RegWriteE   = ctrl_q_s.reg_write;
  assign ResultSrcE  = ctrl_q_s.result_src;
  assign MemWriteE   = ctrl_q_s.mem_write;
  assign JumpE       = ctrl_q_s.jump;
  assign BranchE     = ctrl_q_s.branch;
  assign ALUControlE = ctrl_q_s.alu_control;
  assign ALUSrcE     = ctrl_q_s.alu_src;
  assign BubbleCntE  = bubble_cnt_r;

endmodule
